// File: rtl/tetris_pkg.sv
// Shared board geometry and types for the Tetris board memory.
//   BOARD_COLS/ROWS : board size in cells
//   CELL_PX         : cell edge length in pixels
//   BOARD_CELLS     : number of board memory entries
//   cell_color_t    : 3-bit cell colour, 0 = empty
//   cell_addr_t     : row-major cell index (row*10 + col)
//   arb_state_t     : arbiter FSM states
package tetris_pkg;

  localparam int BOARD_COLS  = 10;
  localparam int BOARD_ROWS  = 20;
  localparam int CELL_PX     = 16;
  localparam int BOARD_CELLS = 200;

  typedef logic [2:0] cell_color_t;
  typedef logic [7:0] cell_addr_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_t;

endpackage

// File: rtl/board_ram.sv
// 200 x 3-bit single-port synchronous RAM holding the board cells.
// Read data appears one cycle after an enabled access; a write returns the
// old contents on rdata.
//   clk   : system clock
//   en    : access enable (read and/or write this cycle)
//   we    : write enable, qualified by en
//   addr  : cell index, must be < BOARD_CELLS when en is high
//   wdata : colour to write
//   rdata : registered read data
module board_ram
  import tetris_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic        we,
  input  cell_addr_t  addr,
  input  cell_color_t wdata,
  output cell_color_t rdata
);

  cell_color_t mem [BOARD_CELLS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/board_mem_arbiter.sv
// Board memory owner and single-port arbiter for the Tetris board.
// Prefetches each cell's colour a few pixels ahead of the VGA beam and
// presents it as a registered value, serves game-engine reads/writes through
// a req/gnt handshake, and runs a self-timed clear sweep.
// Priority: VGA fetch > clear sweep > game.
//   clk, reset         : system clock, synchronous active-high reset
//   vga_row, vga_col   : current beam position
//   vga_cell_color     : colour of the cell under the beam (0 = empty)
//   vga_in_board       : beam is inside the board area
//   gm_req/we/addr/wdata : game request, held until gm_gnt
//   gm_gnt             : combinational grant, access performed this cycle
//   gm_rvalid/gm_rdata : read return, one cycle after a read grant
//   clear_start        : pulse that starts the clear sweep
//   clear_busy         : clear sweep in progress
module board_mem_arbiter
  import tetris_pkg::*;
#(
  parameter int BOARD_X0 = 240,
  parameter int BOARD_Y0 = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  vga_row,
  input  logic [9:0]  vga_col,
  output cell_color_t vga_cell_color,
  output logic        vga_in_board,
  input  logic        gm_req,
  input  logic        gm_we,
  input  cell_addr_t  gm_addr,
  input  cell_color_t gm_wdata,
  output logic        gm_gnt,
  output logic        gm_rvalid,
  output cell_color_t gm_rdata,
  input  logic        clear_start,
  output logic        clear_busy
);

  // Fetches run one cell ahead of the displayed window, at column phase 12,
  // so the colour is in the pending register before the cell's first pixel.
  localparam logic [9:0] Y_LO       = 10'(BOARD_Y0);
  localparam logic [9:0] Y_HI       = 10'(BOARD_Y0 + BOARD_ROWS * CELL_PX);
  localparam logic [9:0] X_FETCH_LO = 10'(BOARD_X0 - CELL_PX);
  localparam logic [9:0] X_FETCH_HI = 10'(BOARD_X0 + (BOARD_COLS - 1) * CELL_PX);
  localparam logic [9:0] X_LO       = 10'(BOARD_X0);
  localparam logic [9:0] X_HI       = 10'(BOARD_X0 + BOARD_COLS * CELL_PX);
  localparam cell_addr_t LAST_CELL  = 8'(BOARD_CELLS - 1);

  logic        row_in;
  logic        fetch_col_in;
  logic        disp_col_in;
  logic        fetch;
  logic        fetched;
  logic        fetch_p1;
  logic [9:0]  dy;
  logic [9:0]  dx;
  cell_addr_t  row_base;
  cell_addr_t  fetch_addr;
  cell_color_t pending;

  arb_state_t  state;
  cell_addr_t  clr_cnt;
  logic        clear_wr;
  logic        gm_in_range;
  logic        gm_access;
  logic        rd_oob_p1;

  logic        ram_en;
  logic        ram_we;
  cell_addr_t  ram_addr;
  cell_color_t ram_wdata;
  cell_color_t ram_rdata;

  assign row_in       = (vga_row >= Y_LO) && (vga_row < Y_HI);
  assign fetch_col_in = (vga_col >= X_FETCH_LO) && (vga_col < X_FETCH_HI);
  assign disp_col_in  = (vga_col >= X_LO) && (vga_col < X_HI);

  // The fetched flag makes a column held for several clocks fetch only once.
  assign fetch = row_in && fetch_col_in && (vga_col[3:0] == 4'd12) && !fetched;

  assign dy         = vga_row - Y_LO;
  assign dx         = vga_col - X_FETCH_LO;
  assign row_base   = {3'b000, dy[8:4]} * 8'd10;
  assign fetch_addr = row_base + {4'b0000, dx[7:4]};

  assign clear_wr    = (state == CLEAR) && !fetch;
  assign gm_in_range = gm_addr < 8'(BOARD_CELLS);
  assign gm_gnt      = gm_req && !fetch && (state == IDLE);
  assign gm_access   = gm_gnt && gm_in_range;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = gm_addr;
    ram_wdata = gm_wdata;
    if (fetch) begin
      ram_en   = 1'b1;
      ram_addr = fetch_addr;
    end else if (clear_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = '0;
    end else if (gm_access) begin
      ram_en = 1'b1;
      ram_we = gm_we;
    end
  end

  board_ram u_board_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p0 -> p1: fetch issued, RAM read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched  <= 1'b0;
      fetch_p1 <= 1'b0;
    end else begin
      fetch_p1 <= fetch;
      if (fetch) begin
        fetched <= 1'b1;
      end else if (vga_col[3:0] != 4'd12) begin
        fetched <= 1'b0;
      end
    end
  end

  // Stage p1 -> pending: fetched colour captured, then shown at cell entry
  always_ff @(posedge clk) begin
    if (reset) begin
      pending        <= '0;
      vga_cell_color <= '0;
      vga_in_board   <= 1'b0;
    end else begin
      if (fetch_p1) begin
        pending <= ram_rdata;
      end
      if (!(row_in && disp_col_in)) begin
        vga_cell_color <= '0;
        vga_in_board   <= 1'b0;
      end else if (vga_col[3:0] == 4'd0) begin
        vga_cell_color <= pending;
        vga_in_board   <= 1'b1;
      end
    end
  end

  // Stage p0 -> p1: game read grant to read return
  always_ff @(posedge clk) begin
    if (reset) begin
      gm_rvalid <= 1'b0;
    end else begin
      gm_rvalid <= gm_gnt && !gm_we;
    end
  end

  always_ff @(posedge clk) begin
    rd_oob_p1 <= !gm_in_range;
  end

  // Out-of-range reads are granted but never touch memory, so they return 0.
  assign gm_rdata = (gm_rvalid && !rd_oob_p1) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          // The sweep stalls on cycles the VGA path owns the port.
          if (!fetch) begin
            clr_cnt <= clr_cnt + 8'd1;
            if (clr_cnt == LAST_CELL) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
module tb_board_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] vga_row;
  logic [9:0] vga_col;
  logic [2:0] vga_cell_color;
  logic       vga_in_board;
  logic       gm_req;
  logic       gm_we;
  logic [7:0] gm_addr;
  logic [2:0] gm_wdata;
  logic       gm_gnt;
  logic       gm_rvalid;
  logic [2:0] gm_rdata;
  logic       clear_start;
  logic       clear_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  board_mem_arbiter #(
    .BOARD_X0 (240),
    .BOARD_Y0 (80)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vga_row        (vga_row),
    .vga_col        (vga_col),
    .vga_cell_color (vga_cell_color),
    .vga_in_board   (vga_in_board),
    .gm_req         (gm_req),
    .gm_we          (gm_we),
    .gm_addr        (gm_addr),
    .gm_wdata       (gm_wdata),
    .gm_gnt         (gm_gnt),
    .gm_rvalid      (gm_rvalid),
    .gm_rdata       (gm_rdata),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gm_write(input logic [7:0] a, input logic [2:0] d);
    gm_req   = 1'b1;
    gm_we    = 1'b1;
    gm_addr  = a;
    gm_wdata = d;
    #1;
    chk($sformatf("wr_gnt_%0d", a), 32'(gm_gnt), 32'd1);
    tick();
    gm_req = 1'b0;
    gm_we  = 1'b0;
  endtask

  task automatic gm_read(input logic [7:0] a, input logic [2:0] exp);
    gm_req  = 1'b1;
    gm_we   = 1'b0;
    gm_addr = a;
    #1;
    chk($sformatf("rd_gnt_%0d", a), 32'(gm_gnt), 32'd1);
    tick();
    gm_req = 1'b0;
    #1;
    chk($sformatf("rd_valid_%0d", a), 32'(gm_rvalid), 32'd1);
    chk($sformatf("rd_data_%0d", a), 32'(gm_rdata), 32'(exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    reset       = 1'b1;
    vga_row     = 10'd0;
    vga_col     = 10'd0;
    gm_req      = 1'b0;
    gm_we       = 1'b0;
    gm_addr     = 8'd0;
    gm_wdata    = 3'd0;
    clear_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_color", 32'(vga_cell_color), 32'd0);
    chk("rst_in_board", 32'(vga_in_board), 32'd0);
    chk("rst_rvalid", 32'(gm_rvalid), 32'd0);
    chk("rst_rdata", 32'(gm_rdata), 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);

    // Write then read back, and read-after-write on the next cycle
    gm_write(8'd37, 3'd5);
    gm_read(8'd37, 3'd5);
    gm_write(8'd38, 3'd4);
    gm_read(8'd38, 3'd4);

    // VGA fetch wins over a held game read; col held for two clocks
    gm_write(8'd0, 3'd2);
    vga_col = 10'd236;
    vga_row = 10'd80;
    gm_req  = 1'b1;
    gm_we   = 1'b0;
    gm_addr = 8'd37;
    #1;
    chk("prio_gnt_withheld", 32'(gm_gnt), 32'd0);
    tick();
    chk("prio_gnt_second", 32'(gm_gnt), 32'd1);
    tick();
    gm_req  = 1'b0;
    vga_row = 10'd0;
    vga_col = 10'd0;
    #1;
    chk("prio_rvalid", 32'(gm_rvalid), 32'd1);
    chk("prio_rdata", 32'(gm_rdata), 32'd5);
    tick();

    // Scan-out of cells 0 and 1
    gm_write(8'd0, 3'd3);
    gm_write(8'd1, 3'd6);
    vga_col = 10'd200;
    vga_row = 10'd80;
    tick();
    for (int c = 236; c <= 272; c++) begin
      vga_col = 10'(c);
      #1;
      if (c == 240) chk("scan_pre_in_board", 32'(vga_in_board), 32'd0);
      if (c == 241) chk("scan_c0_color", 32'(vga_cell_color), 32'd3);
      if (c == 241) chk("scan_c0_in_board", 32'(vga_in_board), 32'd1);
      if (c == 256) chk("scan_c0_hold", 32'(vga_cell_color), 32'd3);
      if (c == 257) chk("scan_c1_color", 32'(vga_cell_color), 32'd6);
      tick();
    end
    vga_col = 10'd400;
    tick();
    chk("scan_exit_color", 32'(vga_cell_color), 32'd0);
    chk("scan_exit_in_board", 32'(vga_in_board), 32'd0);
    vga_row = 10'd0;
    vga_col = 10'd0;
    tick();

    // Out-of-range address
    gm_write(8'd200, 3'd7);
    gm_read(8'd200, 3'd0);

    // Clear sweep with a game read raised midway
    for (int i = 0; i < 200; i++) gm_write(8'(i), 3'd7);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    cycles = 0;
    while (clear_busy && cycles < 400) begin
      cycles++;
      if (cycles == 100) begin
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 8'd5;
        #1;
        chk("clear_gnt_blocked", 32'(gm_gnt), 32'd0);
      end
      tick();
    end
    chk("clear_len", 32'(cycles), 32'd200);
    #1;
    chk("clear_gnt_after", 32'(gm_gnt), 32'd1);
    tick();
    gm_req = 1'b0;
    #1;
    chk("clear_pend_rvalid", 32'(gm_rvalid), 32'd1);
    chk("clear_pend_rdata", 32'(gm_rdata), 32'd0);
    for (int i = 0; i < 200; i++) gm_read(8'(i), 3'd0);

    // Simultaneous start and request, then reset mid-sweep at clr_cnt=50
    for (int i = 0; i < 200; i++) gm_write(8'(i), 3'd7);
    gm_req      = 1'b1;
    gm_we       = 1'b0;
    gm_addr     = 8'd120;
    clear_start = 1'b1;
    #1;
    chk("start_gnt_game", 32'(gm_gnt), 32'd1);
    tick();
    clear_start = 1'b0;
    gm_req      = 1'b0;
    #1;
    chk("start_busy", 32'(clear_busy), 32'd1);
    chk("start_rvalid", 32'(gm_rvalid), 32'd1);
    chk("start_rdata", 32'(gm_rdata), 32'd7);
    repeat (50) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(clear_busy), 32'd0);
    gm_read(8'd49, 3'd0);
    gm_read(8'd51, 3'd7);
    gm_read(8'd120, 3'd7);

    // Reset during a read grant suppresses the rvalid pulse
    gm_req  = 1'b1;
    gm_we   = 1'b0;
    gm_addr = 8'd120;
    reset   = 1'b1;
    tick();
    gm_req = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_read_rvalid", 32'(gm_rvalid), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
